display_scan_driver: RTL and testbench

- Receiving end of the display selector's 2-bit encoded path.
- Takes the muxed code plus the selector line and drives a 4-digit, time-multiplexed, common-anode 7-segment display.
- Filters input glitches, scans the digits, and blinks the display on the alarm code.
- Sits between the display selector and the board's display pins.

---
 rtl/display_scan_driver.sv | 201 ++++++++++++++++++++
 tb/tb_display_scan_driver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_driver.sv
// ---------------------------------------------------------------------------
// display_scan_driver
//
// Receiving end of the display selector's 2-bit encoded path. Synchronises
// {selector, code}, filters glitches with a tick-based stability counter,
// time-multiplexes a 4-digit common-anode 7-segment display and blinks the
// whole display while the committed code is the alarm code (2'b11).
//
// Ports:
//   clock          in   system clock
//   reset_n        in   synchronous, active-low reset
//   selector       in   0 = water subsystem, 1 = irrigation subsystem
//   encoded_Bit0   in   code LSB
//   encoded_Bit1   in   code MSB
//   segments       out  active-low segments, [6:0] = g,f,e,d,c,b,a
//   digit_enable   out  active-low anodes, [3] = leftmost digit
//   decimal_point  out  active-low decimal point
//   code_valid     out  high once a first code has been committed
//
// Optional build macro: DISPLAY_DP_HEARTBEAT_EN
//   Defined   : DP lights on digit0 while a heartbeat bit (toggling every
//               BLINK_FRAMES frames) is set, masked like the digit itself.
//   Undefined : decimal_point is tied high.
// ---------------------------------------------------------------------------
module display_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int STABLE_TICKS = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       selector,
  input  logic       encoded_Bit0,
  input  logic       encoded_Bit1,
  output logic [6:0] segments,
  output logic [3:0] digit_enable,
  output logic       decimal_point,
  output logic       code_valid
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STB_W = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_TICKS);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  // Glyph for a given digit position and committed {selector, code}.
  function automatic logic [6:0] glyph(input logic [1:0] idx, input logic [2:0] code);
    logic [6:0] g;
    g = 7'b1111111;
    case (idx)
      2'd3: g = code[2] ? 7'b1000110 : 7'b0001000;  // 'C' : 'A'
      2'd2: g = 7'b0111111;                         // '-'
      2'd1: g = 7'b1111111;                         // blank
      default: begin
        case (code[1:0])
          2'd0:    g = 7'b1000000;
          2'd1:    g = 7'b1111001;
          2'd2:    g = 7'b0100100;
          default: g = 7'b0110000;
        endcase
      end
    endcase
    return g;
  endfunction

  logic [2:0]       sync1_q, sync2_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [2:0]       cand_q, cand_d;
  logic [STB_W-1:0] stb_q, stb_d;
  logic [2:0]       comm_q, comm_d;
  logic             valid_q, valid_d;
  logic             phase_q, phase_d;
  logic [FRM_W-1:0] frame_q, frame_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       en_q, en_d;

  logic tick, tick_next, wrap, commit, alarm;

  always_comb begin
    tick      = (div_q == DIV_LAST);
    div_d     = tick ? '0 : div_q + 1'b1;
    // Blank the anodes during the cycle in which the next tick fires, so the
    // digit change never shows old segments on the new anode.
    tick_next = (div_d == DIV_LAST);
    wrap      = tick && (idx_q == 2'd3);
    idx_d     = tick ? idx_q + 2'd1 : idx_q;

    commit = 1'b0;
    cand_d = cand_q;
    stb_d  = stb_q;
    if (tick) begin
      if (sync2_q != cand_q) begin
        cand_d = sync2_q;
        stb_d  = '0;
      end else if (stb_q < STB_MAX) begin
        stb_d = stb_q + 1'b1;
        // Commit exactly once, on the tick the count reaches its limit.
        if (stb_d == STB_MAX) commit = 1'b1;
      end
    end

    comm_d  = commit ? cand_q : comm_q;
    valid_d = valid_q | commit;

    alarm   = (comm_q[1:0] == 2'b11);
    phase_d = phase_q;
    frame_d = frame_q;
    if (commit || !alarm) begin
      phase_d = 1'b1;
      frame_d = '0;
    end else if (wrap) begin
      if (frame_q == FRM_LAST) begin
        phase_d = ~phase_q;
        frame_d = '0;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    // Outputs are built from next-state values so a commit coinciding with a
    // tick is reflected on the very next digit shown.
    seg_d = glyph(idx_d, comm_d);
    en_d  = (tick_next || !valid_d || !phase_d) ? 4'b1111 : ~(4'b0001 << idx_d);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      cand_q  <= '0;
      stb_q   <= '0;
      comm_q  <= '0;
      valid_q <= 1'b0;
      phase_q <= 1'b1;
      frame_q <= '0;
      seg_q   <= 7'b1111111;
      en_q    <= 4'b1111;
    end else begin
      sync1_q <= {selector, encoded_Bit1, encoded_Bit0};
      sync2_q <= sync1_q;
      div_q   <= div_d;
      idx_q   <= idx_d;
      cand_q  <= cand_d;
      stb_q   <= stb_d;
      comm_q  <= comm_d;
      valid_q <= valid_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
    end
  end

  assign segments     = seg_q;
  assign digit_enable = en_q;
  assign code_valid   = valid_q;

`ifdef DISPLAY_DP_HEARTBEAT_EN
  logic             hb_q, hb_d;
  logic [FRM_W-1:0] hb_frame_q, hb_frame_d;
  logic             dp_q, dp_d;

  always_comb begin
    hb_d       = hb_q;
    hb_frame_d = hb_frame_q;
    if (wrap) begin
      if (hb_frame_q == FRM_LAST) begin
        hb_d       = ~hb_q;
        hb_frame_d = '0;
      end else begin
        hb_frame_d = hb_frame_q + 1'b1;
      end
    end
    // Follows digit0's anode, so ghost blanking and alarm-off mask it too.
    dp_d = !(!en_d[0] && hb_d);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hb_q       <= 1'b0;
      hb_frame_q <= '0;
      dp_q       <= 1'b1;
    end else begin
      hb_q       <= hb_d;
      hb_frame_q <= hb_frame_d;
      dp_q       <= dp_d;
    end
  end

  assign decimal_point = dp_q;
`else
  assign decimal_point = 1'b1;
`endif

endmodule

// File: tb/tb_display_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_display_scan_driver
//
// Drives display_scan_driver (SCAN_DIV=4, STABLE_TICKS=2, BLINK_FRAMES=2)
// with directed and random {selector, code} sequences and reset pulses.
// A reference model describes the display in terms of elapsed cycles,
// run lengths of sampled inputs and wrap counts, and every output is
// compared each cycle.
// ---------------------------------------------------------------------------
module tb_display_scan_driver;

  localparam int SD = 4;
  localparam int ST = 2;
  localparam int BF = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       selector = 1'b0;
  logic       encoded_Bit0 = 1'b0;
  logic       encoded_Bit1 = 1'b0;
  logic [6:0] segments;
  logic [3:0] digit_enable;
  logic       decimal_point;
  logic       code_valid;

  display_scan_driver #(
    .SCAN_DIV    (SD),
    .STABLE_TICKS(ST),
    .BLINK_FRAMES(BF)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .selector     (selector),
    .encoded_Bit0 (encoded_Bit0),
    .encoded_Bit1 (encoded_Bit1),
    .segments     (segments),
    .digit_enable (digit_enable),
    .decimal_point(decimal_point),
    .code_valid   (code_valid)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int txn   = 0;

  // Reference model state
  int         m;          // cycle index since the last reset edge
  logic [2:0] hist[$];    // input applied during each cycle since reset
  logic [2:0] last_s;     // most recent sampled value
  int         run;        // length of the current run of equal samples
  logic [2:0] com;        // committed {selector, code}
  logic       valid;
  int         w;          // digit3->digit0 wraps since the last commit
  int         wall;       // wraps since reset

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, m, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_glyph(input int idx, input logic [2:0] c);
    logic [6:0] numerals [4];
    numerals[0] = 7'b1000000;
    numerals[1] = 7'b1111001;
    numerals[2] = 7'b0100100;
    numerals[3] = 7'b0110000;
    if (idx == 3) return c[2] ? 7'b1000110 : 7'b0001000;
    if (idx == 2) return 7'b0111111;
    if (idx == 1) return 7'b1111111;
    return numerals[c[1:0]];
  endfunction

  function automatic logic model_phase_on();
    if (com[1:0] != 2'b11) return 1'b1;
    return ((w / BF) % 2) == 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    m      = 0;
    last_s = 3'b000;
    run    = 1;    // the cleared candidate counts as one prior sample
    com    = 3'b000;
    valid  = 1'b0;
    w      = 0;
    wall   = 0;
  endtask

  // Scan tick at the edge that ends cycle n.
  task automatic model_tick(input int n);
    logic [2:0] s;
    logic       wrapped;
    logic       committed_now;
    s = (n >= 2) ? hist[n-2] : 3'b000;  // two-flop synchroniser delay
    wrapped = ((n / SD) % 4) == 3;
    if (s == last_s) run++;
    else begin
      last_s = s;
      run    = 1;
    end
    committed_now = (run == ST + 1);
    if (committed_now) begin
      com   = s;
      valid = 1'b1;
      w     = 0;
    end else if (wrapped) begin
      w++;
    end
    if (wrapped) wall++;
  endtask

  task automatic check_cycle();
    logic [3:0] en_exp;
    logic       dp_exp;
    int         idx;
    if (m == 0) begin
      chk("rst_seg",   32'(segments),      32'h7F);
      chk("rst_en",    32'(digit_enable),  32'hF);
      chk("rst_dp",    32'(decimal_point), 32'h1);
      chk("rst_valid", 32'(code_valid),    32'h0);
    end else begin
      idx = (m / SD) % 4;
      if ((m % SD) == SD - 1 || !valid || !model_phase_on())
        en_exp = 4'b1111;
      else
        en_exp = ~(4'b0001 << idx);
`ifdef DISPLAY_DP_HEARTBEAT_EN
      dp_exp = !(!en_exp[0] && (((wall / BF) % 2) == 1));
`else
      dp_exp = 1'b1;
`endif
      chk("enable", 32'(digit_enable),  32'(en_exp));
      chk("valid",  32'(code_valid),    32'(valid));
      chk("dp",     32'(decimal_point), 32'(dp_exp));
      if (valid) chk("segments", 32'(segments), 32'(exp_glyph(idx, com)));
    end
  endtask

  // Apply inputs for one cycle, let the edge happen, update model, check.
  task automatic step(input logic rst_v, input logic [2:0] in_v);
    reset_n = rst_v;
    {selector, encoded_Bit1, encoded_Bit0} = in_v;
    @(posedge clock);
    #1;
    if (!rst_v) model_reset();
    else begin
      hist.push_back(in_v);
      if ((m % SD) == SD - 1) model_tick(m);
      m++;
    end
    check_cycle();
  endtask

  task automatic hold(input logic rst_v, input logic [2:0] in_v, input int cycles);
    for (int i = 0; i < cycles; i++) step(rst_v, in_v);
    txn++;
    $display("txn %0d: reset_n=%b sel=%b code=%b cycles=%0d valid=%b", txn, rst_v,
             in_v[2], in_v[1:0], cycles, code_valid);
  endtask

  initial begin
    int budget;
    logic [2:0] r_in;
    int r_len;
    model_reset();

    // Reset, then hold selector=0, code=01 until well after the commit.
    hold(1'b0, 3'b001, 2);
    hold(1'b1, 3'b001, 80);

    // Glitch: code 10 for a single tick, then back to 01.
    hold(1'b1, 3'b010, SD);
    hold(1'b1, 3'b001, 60);

    // Alarm on the irrigation subsystem: several blink periods.
    hold(1'b1, 3'b111, 250);

    // Continue until the blink is in its off phase, then reset for one cycle.
    budget = 0;
    while (!(valid && !model_phase_on()) && budget < 200) begin
      step(1'b1, 3'b111);
      budget++;
    end
    chk("alarm_off_reached", 32'(valid && !model_phase_on()), 32'h1);
    hold(1'b0, 3'b111, 1);
    hold(1'b1, 3'b111, 60);

    // Leave alarm: code 00 restores a steady display after the commit delay.
    hold(1'b1, 3'b100, 100);

    // Alarm to alarm with a changed selector restarts the blink.
    hold(1'b1, 3'b111, 90);
    hold(1'b1, 3'b011, 90);

    // Random traffic with occasional reset pulses.
    for (int t = 0; t < 60; t++) begin
      r_in = 3'($urandom_range(0, 7));
      if (r_in[1:0] == 2'b11) r_len = $urandom_range(20, 120);
      else                    r_len = $urandom_range(2, 30);
      if ($urandom_range(0, 15) == 0) hold(1'b0, r_in, $urandom_range(1, 2));
      hold(1'b1, r_in, r_len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
